led_pwm_engine: RTL and testbench

- Multi-channel LED PWM driver with a shared prescaler and PWM counter, and per-channel modes: off, static, blink and breathe (triangle fade).
- Successor to the fixed three-bit-tap RGB blinker; generalises channel count, resolution and rate.
- Configured through a single valid/ready write port.
- Duty changes take effect only at PWM period boundaries, so the outputs are glitch-free.

---
 rtl/led_pwm_pkg.sv | 11 +
 rtl/led_pwm_engine_if.sv | 19 +
 rtl/led_pwm_channel.sv | 87 ++++++++
 rtl/led_pwm_engine.sv | 118 +++++++++++
 tb/tb_led_pwm_engine.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/led_pwm_pkg.sv
// Shared mode encoding for the LED PWM engine and its channels.
package led_pwm_pkg;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_OFF     = 2'd0;
   localparam mode_t MODE_STATIC  = 2'd1;
   localparam mode_t MODE_BLINK   = 2'd2;
   localparam mode_t MODE_BREATHE = 2'd3;

endpackage

// File: rtl/led_pwm_engine_if.sv
// Configuration write port of the LED PWM engine: valid/ready plus error pulse.
interface led_pwm_engine_if #(
   parameter int unsigned CH_W  = 2,
   parameter int unsigned PWM_W = 8
) ();
   import led_pwm_pkg::*;

   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   mode_t            cfg_mode;
   logic [PWM_W-1:0] cfg_level;
   logic             cfg_err;

   modport master (output cfg_valid, cfg_ch, cfg_mode, cfg_level,
                   input  cfg_ready, cfg_err);
   modport slave  (input  cfg_valid, cfg_ch, cfg_mode, cfg_level,
                   output cfg_ready, cfg_err);
endinterface

// File: rtl/led_pwm_channel.sv
// One LED channel: committed mode/level, breathe fade state, per-period duty and PWM compare.
module led_pwm_channel
   import led_pwm_pkg::*;
#(
   parameter int unsigned PWM_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             boundary_i,
   input  logic             commit_i,
   input  logic             phase_i,
   input  mode_t            mode_i,
   input  logic [PWM_W-1:0] level_i,
   input  logic [PWM_W-1:0] pwm_cnt_i,
   output logic             led_o
);

   mode_t            mode_q,    mode_d;
   logic [PWM_W-1:0] level_q,   level_d;
   logic [PWM_W-1:0] fade_q,    fade_d;
   logic             dir_dn_q,  dir_dn_d;
   logic [PWM_W-1:0] duty_q,    duty_d;
   logic             led_q,     led_d;

   always_comb begin
      mode_d   = mode_q;
      level_d  = level_q;
      fade_d   = fade_q;
      dir_dn_d = dir_dn_q;
      duty_d   = duty_q;
      led_d    = (pwm_cnt_i < duty_q);

      if (boundary_i) begin
         // A fresh commit restarts the fade and skips this boundary's step
         if (commit_i) begin
            mode_d   = mode_i;
            level_d  = level_i;
            fade_d   = '0;
            dir_dn_d = 1'b0;
         end else if (mode_q == MODE_BREATHE) begin
            if (level_q == '0) begin
               fade_d = '0;
            end else if (!dir_dn_q) begin
               if (fade_q >= level_q) begin
                  dir_dn_d = 1'b1;
                  fade_d   = fade_q - PWM_W'(1);
               end else begin
                  fade_d   = fade_q + PWM_W'(1);
               end
            end else if (fade_q == '0) begin
               dir_dn_d = 1'b0;
               fade_d   = PWM_W'(1);
            end else begin
               fade_d   = fade_q - PWM_W'(1);
            end
         end

         case (mode_d)
            MODE_OFF:     duty_d = '0;
            MODE_STATIC:  duty_d = level_d;
            MODE_BLINK:   duty_d = phase_i ? level_d : '0;
            MODE_BREATHE: duty_d = fade_d;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q   <= MODE_OFF;
         level_q  <= '0;
         fade_q   <= '0;
         dir_dn_q <= 1'b0;
         duty_q   <= '0;
         led_q    <= 1'b0;
      end else begin
         mode_q   <= mode_d;
         level_q  <= level_d;
         fade_q   <= fade_d;
         dir_dn_q <= dir_dn_d;
         duty_q   <= duty_d;
         led_q    <= led_d;
      end
   end

   assign led_o = led_q;

endmodule

// File: rtl/led_pwm_engine.sv
// Multi-channel LED PWM engine: shared timebase, blink phase, and a one-deep config shadow
// that commits only at PWM period boundaries.
module led_pwm_engine
   import led_pwm_pkg::*;
#(
   parameter int unsigned CHANNELS = 3,
   parameter int unsigned PWM_W    = 8,
   parameter int unsigned PRESC_W  = 4,
   parameter int unsigned BLINK_W  = 3
) (
   input  logic                clk,
   input  logic                rst,
   led_pwm_engine_if.slave     cfg,
   output logic                period_tick,
   output logic [CHANNELS-1:0] led
);

   localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [PRESC_W-1:0] presc_q,       presc_d;
   logic [PWM_W-1:0]   pwm_cnt_q,     pwm_cnt_d;
   logic [BLINK_W-1:0] blink_cnt_q,   blink_cnt_d;
   logic               phase_q,       phase_d;
   logic               period_tick_q, period_tick_d;
   logic               pending_q,     pending_d;
   logic               ready_q,       ready_d;
   logic               err_q,         err_d;
   logic [CH_W-1:0]    sh_ch_q,       sh_ch_d;
   mode_t              sh_mode_q,     sh_mode_d;
   logic [PWM_W-1:0]   sh_level_q,    sh_level_d;

   logic tick;
   logic boundary;
   logic accept;
   logic ch_ok;

   always_comb begin
      tick          = (presc_q == '1);
      boundary      = tick && (pwm_cnt_q == '1);
      presc_d       = presc_q + PRESC_W'(1);
      pwm_cnt_d     = tick ? pwm_cnt_q + PWM_W'(1) : pwm_cnt_q;
      blink_cnt_d   = boundary ? blink_cnt_q + BLINK_W'(1) : blink_cnt_q;
      phase_d       = phase_q ^ (boundary && (blink_cnt_q == '1));
      period_tick_d = boundary;

      accept     = cfg.cfg_valid && ready_q;
      ch_ok      = (32'(cfg.cfg_ch) < CHANNELS);
      pending_d  = pending_q;
      sh_ch_d    = sh_ch_q;
      sh_mode_d  = sh_mode_q;
      sh_level_d = sh_level_q;
      err_d      = 1'b0;

      // Ready implies nothing pending, so an accept never collides with a commit
      if (boundary && pending_q) pending_d = 1'b0;
      if (accept) begin
         if (ch_ok) begin
            pending_d  = 1'b1;
            sh_ch_d    = cfg.cfg_ch;
            sh_mode_d  = cfg.cfg_mode;
            sh_level_d = cfg.cfg_level;
         end else begin
            err_d      = 1'b1;
         end
      end
      ready_d = !pending_d;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         presc_q       <= '0;
         pwm_cnt_q     <= '0;
         blink_cnt_q   <= '0;
         phase_q       <= 1'b0;
         period_tick_q <= 1'b0;
         pending_q     <= 1'b0;
         ready_q       <= 1'b0;
         err_q         <= 1'b0;
         sh_ch_q       <= '0;
         sh_mode_q     <= MODE_OFF;
         sh_level_q    <= '0;
      end else begin
         presc_q       <= presc_d;
         pwm_cnt_q     <= pwm_cnt_d;
         blink_cnt_q   <= blink_cnt_d;
         phase_q       <= phase_d;
         period_tick_q <= period_tick_d;
         pending_q     <= pending_d;
         ready_q       <= ready_d;
         err_q         <= err_d;
         sh_ch_q       <= sh_ch_d;
         sh_mode_q     <= sh_mode_d;
         sh_level_q    <= sh_level_d;
      end
   end

   assign cfg.cfg_ready = ready_q;
   assign cfg.cfg_err   = err_q;
   assign period_tick   = period_tick_q;

   for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_ch
      logic commit;
      assign commit = boundary && pending_q && (sh_ch_q == CH_W'(i));

      led_pwm_channel #(.PWM_W(PWM_W)) u_ch (
         .clk        (clk),
         .rst        (rst),
         .boundary_i (boundary),
         .commit_i   (commit),
         .phase_i    (phase_d),
         .mode_i     (sh_mode_q),
         .level_i    (sh_level_q),
         .pwm_cnt_i  (pwm_cnt_q),
         .led_o      (led[i])
      );
   end

endmodule

// File: tb/tb_led_pwm_engine.sv
// Directed bench for led_pwm_engine (3 channels, 4-bit PWM, 32-cycle periods).
module tb_led_pwm_engine;
   import led_pwm_pkg::*;

   localparam int unsigned PER = 32;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       period_tick;
   logic [2:0] led;

   int unsigned cyc;
   int          n_checks = 0;
   int          n_errors = 0;
   int          hi [0:2][0:15];
   int          p0;
   int          w;

   led_pwm_engine_if #(.CH_W(2), .PWM_W(4)) cfg_if ();

   led_pwm_engine #(
      .CHANNELS (3),
      .PWM_W    (4),
      .PRESC_W  (1),
      .BLINK_W  (1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .cfg         (cfg_if),
      .period_tick (period_tick),
      .led         (led)
   );

   always #5 clk = ~clk;

   // Cycles since reset release; 1 in the first cycle after release
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic sync_period();
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (period_tick !== 1'b1 && n < 40);
      if (period_tick !== 1'b1) check("period_tick_timeout", 32'(period_tick), 32'(1));
   endtask

   // Counts led high cycles for n consecutive periods, starting at a period_tick cycle
   task automatic measure(input int n);
      p0 = int'(cyc / PER);
      for (int j = 0; j < n; j++) begin
         for (int c = 0; c < 3; c++) hi[c][j] = 0;
         for (int k = 0; k < int'(PER); k++) begin
            @(negedge clk);
            for (int c = 0; c < 3; c++) hi[c][j] += int'(led[c]);
         end
      end
   endtask

   task automatic cfg_write(input int ch, input int mode, input int level, output int waited);
      @(negedge clk);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = 2'(ch);
      cfg_if.cfg_mode  = 2'(mode);
      cfg_if.cfg_level = 4'(level);
      waited = 0;
      while (cfg_if.cfg_ready !== 1'b1 && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (cfg_if.cfg_ready !== 1'b1) check("write_timeout", 32'(cfg_if.cfg_ready), 32'(1));
      @(negedge clk);
      cfg_if.cfg_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int breathe_exp [0:8];
      breathe_exp = '{0, 2, 4, 6, 4, 2, 0, 2, 4};
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_mode  = MODE_OFF;
      cfg_if.cfg_level = '0;

      // Reset held 5 cycles
      repeat (5) begin
         @(negedge clk);
         check("rst_led", 32'(led), 32'(0));
         check("rst_tick", 32'(period_tick), 32'(0));
         check("rst_ready", 32'(cfg_if.cfg_ready), 32'(0));
      end
      rst = 1'b0;
      @(negedge clk);
      check("ready_after_rst", 32'(cfg_if.cfg_ready), 32'(1));
      for (int k = 0; k < 95; k++) begin
         @(negedge clk);
         check("period_tick", 32'(period_tick), 32'((cyc % PER) == 0));
         check("idle_led", 32'(led), 32'(0));
      end

      // Static ch0 level 4
      sync_period();
      cfg_write(0, MODE_STATIC, 4, w);
      check("static_ready_low", 32'(cfg_if.cfg_ready), 32'(0));
      sync_period();
      check("static_ready_back", 32'(cfg_if.cfg_ready), 32'(1));
      measure(2);
      check("static_led0_p0", 32'(hi[0][0]), 32'(8));
      check("static_led0_p1", 32'(hi[0][1]), 32'(8));
      check("static_led1", 32'(hi[1][0] + hi[1][1]), 32'(0));
      check("static_led2", 32'(hi[2][0] + hi[2][1]), 32'(0));

      // Back-to-back writes: second held until first commits
      cfg_write(2, MODE_STATIC, 2, w);
      cfg_write(1, MODE_STATIC, 6, w);
      check("bp_held", 32'(w >= 20), 32'(1));
      check("bp_ready_low", 32'(cfg_if.cfg_ready), 32'(0));
      sync_period();
      check("bp_ready_back", 32'(cfg_if.cfg_ready), 32'(1));
      measure(1);
      check("bp_led0", 32'(hi[0][0]), 32'(8));
      check("bp_led1", 32'(hi[1][0]), 32'(12));
      check("bp_led2", 32'(hi[2][0]), 32'(4));

      // Invalid channel
      cfg_write(3, MODE_STATIC, 15, w);
      check("err_pulse", 32'(cfg_if.cfg_err), 32'(1));
      check("err_ready", 32'(cfg_if.cfg_ready), 32'(1));
      @(negedge clk);
      check("err_one_cycle", 32'(cfg_if.cfg_err), 32'(0));
      sync_period();
      measure(1);
      check("err_led0", 32'(hi[0][0]), 32'(8));
      check("err_led1", 32'(hi[1][0]), 32'(12));
      check("err_led2", 32'(hi[2][0]), 32'(4));

      // Breathe ch1 level 3: duty 0,1,2,3,2,1,0,1,2
      cfg_write(1, MODE_BREATHE, 3, w);
      sync_period();
      measure(9);
      for (int j = 0; j < 9; j++) check($sformatf("breathe_p%0d", j), 32'(hi[1][j]), 32'(breathe_exp[j]));
      check("breathe_led0", 32'(hi[0][4]), 32'(8));

      cfg_write(1, MODE_BREATHE, 0, w);
      sync_period();
      measure(2);
      check("breathe0_led1", 32'(hi[1][0] + hi[1][1]), 32'(0));

      // Blink ch2 level 15: phase after boundary k is (k/2)%2
      cfg_write(2, MODE_BLINK, 15, w);
      sync_period();
      measure(4);
      for (int j = 0; j < 4; j++)
         check($sformatf("blink_p%0d", j), 32'(hi[2][j]), 32'((((p0 + j) / 2) % 2) != 0 ? 30 : 0));
      check("blink_led0", 32'(hi[0][3]), 32'(8));

      // Reset during active breathe with a pending write
      cfg_write(1, MODE_BREATHE, 5, w);
      sync_period();
      measure(3);
      check("rb_p0", 32'(hi[1][0]), 32'(0));
      check("rb_p1", 32'(hi[1][1]), 32'(2));
      check("rb_p2", 32'(hi[1][2]), 32'(4));
      cfg_write(0, MODE_STATIC, 15, w);
      check("rb_pending", 32'(cfg_if.cfg_ready), 32'(0));
      rst = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_led", 32'(led), 32'(0));
         check("mid_rst_tick", 32'(period_tick), 32'(0));
         check("mid_rst_ready", 32'(cfg_if.cfg_ready), 32'(0));
      end
      rst = 1'b0;
      @(negedge clk);
      check("mid_rst_ready_back", 32'(cfg_if.cfg_ready), 32'(1));
      sync_period();
      check("mid_rst_first_tick", 32'(cyc), 32'(32));
      measure(2);
      for (int c = 0; c < 3; c++)
         check($sformatf("mid_rst_led%0d", c), 32'(hi[c][0] + hi[c][1]), 32'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
